// File: rtl/seven_segment_capture_x_4.sv
// seven_segment_capture_x_4
// Receive side of a four-digit multiplexed seven-segment display. Samples the
// active-low segment, decimal-point and anode lines, waits for each digit's
// pattern to sit still, decodes it and collects all four digits into a frame
// that is published with a one-cycle frame_valid pulse.
//
// Optional build macro: SSD_CAPTURE_TIMEOUT_EN
//   Defined   - a no-capture watchdog drops partial frames and raises stale.
//   Undefined - stale is tied low and partial frames wait indefinitely.
module seven_segment_capture_x_4 #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2097152
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  a_to_g,
  input  logic        decimal_point,
  input  logic [3:0]  anode,
  output logic [15:0] bcd_out,
  output logic [3:0]  decimal_points_out,
  output logic        frame_valid,
  output logic [3:0]  digit_error,
  output logic        stale
);

  // Pattern layout: {anode[3:0], decimal_point, a_to_g[6:0]}
  localparam int PAT_W    = 12;
  localparam int SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int STABLE_N = (STABLE_CYCLES < 1) ? 1 : STABLE_CYCLES;
  localparam int CNT_W    = $clog2(STABLE_N + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_N - 1);

  // Synchronizer chain; all-ones is a dark display
  logic [PAT_W-1:0] r_sync [SYNC_N];
  logic [PAT_W-1:0] w_pat;

  // Stability tracking
  logic [PAT_W-1:0] r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_same;
  logic             w_arrive;

  // Anode qualification
  logic             w_onehot;
  logic [1:0]       w_idx;
  logic             w_cap;

  // Segment decode
  logic [3:0]       w_dec_nib;
  logic             w_dec_err;
  logic             w_dec_dp;

  // Frame assembly
  logic [3:0][3:0]  r_sh_bcd;
  logic [3:0]       r_sh_dp;
  logic [3:0]       r_sh_err;
  logic [3:0]       r_seen;
  logic [3:0]       w_seen_nxt;
  logic             w_publish;
  logic             w_timeout;

  // Published outputs
  logic [15:0]      r_bcd;
  logic [3:0]       r_dp;
  logic [3:0]       r_err;
  logic             r_frame_valid;

  // Shift every input line through the synchronizer chain
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_N; i++) begin
        r_sync[i] <= '1;
      end
    end else begin
      r_sync[0] <= {anode, decimal_point, a_to_g};
      for (int i = 1; i < SYNC_N; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_pat = r_sync[SYNC_N-1];

  // Count consecutive cycles the synced pattern has held, saturating so a
  // long dwell fires only once
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '1;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_pat;
      if (w_pat != r_prev) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_same   = (w_pat == r_prev);
  assign w_arrive = w_same && (r_cnt == CNT_LAST);

  // Only a single driven digit identifies which shadow slot to fill
  always_comb begin
    w_onehot = 1'b0;
    w_idx    = 2'd0;
    case (w_pat[11:8])
      4'b1110: begin w_onehot = 1'b1; w_idx = 2'd0; end
      4'b1101: begin w_onehot = 1'b1; w_idx = 2'd1; end
      4'b1011: begin w_onehot = 1'b1; w_idx = 2'd2; end
      4'b0111: begin w_onehot = 1'b1; w_idx = 2'd3; end
      default: begin w_onehot = 1'b0; w_idx = 2'd0; end
    endcase
  end

  assign w_cap = w_arrive && w_onehot;

  // Active-low segment patterns (g..a) back to BCD; blank reads as F,
  // anything unrecognised reads as E and is flagged
  always_comb begin
    w_dec_nib = 4'hE;
    w_dec_err = 1'b0;
    case (w_pat[6:0])
      7'b1000000: w_dec_nib = 4'h0;
      7'b1111001: w_dec_nib = 4'h1;
      7'b0100100: w_dec_nib = 4'h2;
      7'b0110000: w_dec_nib = 4'h3;
      7'b0011001: w_dec_nib = 4'h4;
      7'b0010010: w_dec_nib = 4'h5;
      7'b0000010: w_dec_nib = 4'h6;
      7'b1111000: w_dec_nib = 4'h7;
      7'b0000000: w_dec_nib = 4'h8;
      7'b0010000: w_dec_nib = 4'h9;
      7'b1111111: w_dec_nib = 4'hF;
      default: begin
        w_dec_nib = 4'hE;
        w_dec_err = 1'b1;
      end
    endcase
  end

  assign w_dec_dp  = ~w_pat[7];
  assign w_publish = (r_seen == 4'hF);

  // Next seen mask: publish/timeout empty it, a capture in the same cycle
  // belongs to the following frame
  always_comb begin
    w_seen_nxt = r_seen;
    if (w_publish || w_timeout) begin
      w_seen_nxt = 4'h0;
    end
    if (w_cap) begin
      w_seen_nxt[w_idx] = 1'b1;
    end
  end

  // Shadow registers collect the frame under construction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_bcd <= '0;
      r_sh_dp  <= '0;
      r_sh_err <= '0;
      r_seen   <= '0;
    end else begin
      r_seen <= w_seen_nxt;
      if (w_cap) begin
        r_sh_bcd[w_idx] <= w_dec_nib;
        r_sh_dp[w_idx]  <= w_dec_dp;
        r_sh_err[w_idx] <= w_dec_err;
      end
    end
  end

  // Publish the completed frame; shadow is read before any same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bcd         <= '0;
      r_dp          <= '0;
      r_err         <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_publish;
      if (w_publish) begin
        r_bcd <= r_sh_bcd;
        r_dp  <= r_sh_dp;
        r_err <= r_sh_err;
      end
    end
  end

`ifdef SSD_CAPTURE_TIMEOUT_EN
  localparam int TO_N = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int TO_W = $clog2(TO_N + 1);

  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TO_N);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_N - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_stale;

  // The saturating count reaches its limit once per quiet spell
  assign w_timeout = (r_to_cnt == TO_LAST) && !w_cap;

  // Watchdog on captures; stale stays up until a full frame gets through
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else begin
      if (w_cap) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_stale <= 1'b1;
      end else if (w_publish) begin
        r_stale <= 1'b0;
      end
    end
  end

  assign stale = r_stale;
`else
  assign w_timeout = 1'b0;
  assign stale     = 1'b0;
`endif

  assign bcd_out            = r_bcd;
  assign decimal_points_out = r_dp;
  assign digit_error        = r_err;
  assign frame_valid        = r_frame_valid;

endmodule

// File: tb/tb_seven_segment_capture_x_4.sv
// Bench for seven_segment_capture_x_4: table-driven frames, hand-written
// dwell-timing sequences and a randomized dwell stream checked against a
// frame-level reference model.
`timescale 1ns/1ps
module tb_seven_segment_capture_x_4;

`ifdef SSD_CAPTURE_TIMEOUT_EN
  localparam int TO_CYC = 200;
`else
  localparam int TO_CYC = 2097152;
`endif
  localparam int STABLE = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  a_to_g;
  logic        decimal_point;
  logic [3:0]  anode;
  logic [15:0] bcd_out;
  logic [3:0]  decimal_points_out;
  logic        frame_valid;
  logic [3:0]  digit_error;
  logic        stale;

  seven_segment_capture_x_4 #(
    .SYNC_STAGES(2),
    .STABLE_CYCLES(STABLE),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_to_g(a_to_g),
    .decimal_point(decimal_point),
    .anode(anode),
    .bcd_out(bcd_out),
    .decimal_points_out(decimal_points_out),
    .frame_valid(frame_valid),
    .digit_error(digit_error),
    .stale(stale)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] JUNK  = 7'b1010101;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  typedef struct {
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
    logic [15:0]     e_bcd;
    logic [3:0]      e_dp;
    logic [3:0]      e_err;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int fv_count = 0;
  frame_t act_q[$];
  frame_t exp_q[$];

  // Record every published frame
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_count++;
      act_q.push_back(frame_t'({bcd_out, decimal_points_out, digit_error}));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic dwell(input logic [3:0] an, input logic dp_n, input logic [6:0] seg, input int cycles);
    anode         = an;
    decimal_point = dp_n;
    a_to_g        = seg;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic dark(input int cycles);
    dwell(4'hF, 1'b1, BLANK, cycles);
  endtask

  task automatic digit(input int k, input logic [6:0] seg, input logic dp_on, input int cycles);
    logic [3:0] an;
    an = 4'b0001 << k;
    dwell(~an, ~dp_on, seg, cycles);
  endtask

  task automatic run_frame(input logic [3:0][6:0] seg, input logic [3:0] dp, input int cycles);
    for (int k = 3; k >= 0; k--) digit(k, seg[k], dp[k], cycles);
  endtask

  task automatic do_reset();
    anode = 4'hF; decimal_point = 1'b1; a_to_g = BLANK;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (s == SEG_TAB[d]) return {1'b0, 4'(d)};
    if (s == BLANK) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  initial begin
    #500000;
    failures++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    vec_t vecs [4];
    int f0, sel, dur, nc_run, r, k, nmin;
    logic [3:0] an, oh;
    logic [6:0] sg;
    logic dpn;
    logic [11:0] prev;
    logic [4:0] dec;
    logic [3:0][3:0] m_bcd;
    logic [3:0] m_dp, m_err, m_seen;

    vecs[0] = '{{SEG_TAB[4], SEG_TAB[0], SEG_TAB[9], SEG_TAB[7]}, 4'b0100, 16'h4097, 4'b0100, 4'b0000};
    vecs[1] = '{{SEG_TAB[1], JUNK, SEG_TAB[2], SEG_TAB[3]}, 4'b0000, 16'h1E23, 4'b0000, 4'b0100};
    vecs[2] = '{{SEG_TAB[5], SEG_TAB[6], BLANK, SEG_TAB[8]}, 4'b1001, 16'h56F8, 4'b1001, 4'b0000};
    vecs[3] = '{{SEG_TAB[9], SEG_TAB[8], SEG_TAB[7], SEG_TAB[6]}, 4'b1111, 16'h9876, 4'b1111, 4'b0000};

    reset = 1'b1; anode = 4'hF; decimal_point = 1'b1; a_to_g = BLANK;
    @(negedge clk);
    do_reset();
    chk("reset bcd_out", bcd_out, 16'h0);
    chk("reset decimal_points_out", decimal_points_out, 4'h0);
    chk("reset digit_error", digit_error, 4'h0);
    chk("reset frame_valid", frame_valid, 1'b0);
    chk("reset stale", stale, 1'b0);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      f0 = fv_count;
      run_frame(vecs[i].seg, vecs[i].dp, 40);
      chk($sformatf("vec%0d frame count", i), fv_count - f0, 1);
      chk($sformatf("vec%0d bcd_out", i), bcd_out, vecs[i].e_bcd);
      chk($sformatf("vec%0d points", i), decimal_points_out, vecs[i].e_dp);
      chk($sformatf("vec%0d digit_error", i), digit_error, vecs[i].e_err);
    end

    // Dwell boundary: 16 synced cycles must not capture, 17 must
    do_reset();
    f0 = fv_count;
    digit(3, SEG_TAB[1], 1'b0, 40);
    digit(2, SEG_TAB[2], 1'b0, 40);
    digit(1, SEG_TAB[3], 1'b0, 40);
    digit(0, SEG_TAB[7], 1'b0, 16);
    dark(40);
    chk("dwell16 no capture", fv_count - f0, 0);
    digit(0, SEG_TAB[7], 1'b0, 17);
    dark(40);
    chk("dwell17 capture", fv_count - f0, 1);
    chk("dwell17 bcd_out", bcd_out, 16'h1237);

    // A long dwell captures exactly once
    f0 = fv_count;
    digit(3, SEG_TAB[4], 1'b0, 40);
    digit(2, SEG_TAB[5], 1'b0, 40);
    digit(1, SEG_TAB[6], 1'b0, 40);
    digit(0, SEG_TAB[8], 1'b0, 100);
    chk("long dwell frame", fv_count - f0, 1);
    chk("long dwell bcd_out", bcd_out, 16'h4568);
    f0 = fv_count;
    digit(3, SEG_TAB[4], 1'b0, 40);
    digit(2, SEG_TAB[5], 1'b0, 40);
    digit(1, SEG_TAB[6], 1'b0, 40);
    chk("single capture per dwell", fv_count - f0, 0);
    digit(0, SEG_TAB[9], 1'b0, 40);
    chk("after single capture frame", fv_count - f0, 1);
    chk("after single capture bcd", bcd_out, 16'h4569);

    // Toggling every 8 cycles never settles; a 20-cycle hold does
    f0 = fv_count;
    digit(3, SEG_TAB[2], 1'b0, 40);
    digit(2, SEG_TAB[3], 1'b0, 40);
    digit(1, SEG_TAB[4], 1'b0, 40);
    for (int t = 0; t < 6; t++) begin
      digit(0, SEG_TAB[1], 1'b0, 8);
      digit(0, SEG_TAB[7], 1'b0, 8);
    end
    chk("toggle no capture", fv_count - f0, 0);
    digit(0, SEG_TAB[5], 1'b0, 20);
    dark(10);
    chk("toggle then hold frame", fv_count - f0, 1);
    chk("toggle then hold bcd", bcd_out, 16'h2345);

    // Invalid anode patterns never capture
    for (int b = 0; b < 2; b++) begin
      f0 = fv_count;
      digit(3, SEG_TAB[7], 1'b0, 40);
      digit(2, SEG_TAB[8], 1'b0, 40);
      digit(1, SEG_TAB[9], 1'b0, 40);
      dwell((b == 0) ? 4'b1100 : 4'b1111, 1'b0, SEG_TAB[3], 100);
      chk($sformatf("bad anode%0d no capture", b), fv_count - f0, 0);
      digit(0, SEG_TAB[0], 1'b0, 40);
      chk($sformatf("bad anode%0d frame", b), fv_count - f0, 1);
      chk($sformatf("bad anode%0d bcd", b), bcd_out, 16'h7890);
    end

    // Reset mid-frame discards partial captures
    f0 = fv_count;
    run_frame(vecs[0].seg, vecs[0].dp, 40);
    chk("pre-reset frame", fv_count - f0, 1);
    digit(3, SEG_TAB[2], 1'b0, 40);
    digit(2, SEG_TAB[3], 1'b0, 40);
    do_reset();
    chk("mid reset bcd_out", bcd_out, 16'h0);
    chk("mid reset points", decimal_points_out, 4'h0);
    chk("mid reset digit_error", digit_error, 4'h0);
    f0 = fv_count;
    digit(1, SEG_TAB[6], 1'b0, 40);
    digit(0, SEG_TAB[5], 1'b0, 40);
    chk("post reset partial", fv_count - f0, 0);
    digit(3, SEG_TAB[2], 1'b1, 40);
    digit(2, SEG_TAB[1], 1'b0, 40);
    chk("post reset frame", fv_count - f0, 1);
    chk("post reset bcd", bcd_out, 16'h2165);
    chk("post reset points", decimal_points_out, 4'b1000);

    // Partial frame across a long idle
    do_reset();
    f0 = fv_count;
    digit(0, SEG_TAB[1], 1'b0, 40);
    digit(1, SEG_TAB[2], 1'b0, 40);
`ifdef SSD_CAPTURE_TIMEOUT_EN
    dark(220);
    chk("timeout stale set", stale, 1'b1);
    digit(3, SEG_TAB[3], 1'b0, 40);
    digit(2, SEG_TAB[4], 1'b0, 40);
    chk("timeout dropped partial", fv_count - f0, 0);
    chk("stale held", stale, 1'b1);
    digit(1, SEG_TAB[5], 1'b0, 40);
    digit(0, SEG_TAB[6], 1'b0, 40);
    chk("timeout recovery frame", fv_count - f0, 1);
    chk("stale cleared", stale, 1'b0);
    chk("timeout recovery bcd", bcd_out, 16'h3456);
`else
    dark(300);
    chk("idle stale low", stale, 1'b0);
    digit(2, SEG_TAB[3], 1'b0, 40);
    digit(3, SEG_TAB[4], 1'b0, 40);
    chk("partial persists frame", fv_count - f0, 1);
    chk("partial persists bcd", bcd_out, 16'h4321);
`endif

    // Randomized dwell stream against the frame-level model
    do_reset();
    act_q.delete();
    exp_q.delete();
    m_bcd = '0; m_dp = '0; m_err = '0; m_seen = '0;
    prev = 12'hFFF;
    nc_run = 0;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 7);
      oh = 4'b0001 << $urandom_range(0, 3);
      case (sel)
        4: an = 4'b1111;
        5: an = 4'b1100;
        6: an = 4'b0101;
        default: an = ~oh;
      endcase
      r = $urandom_range(0, 9);
      if (r < 7) sg = SEG_TAB[$urandom_range(0, 9)];
      else if (r == 7) sg = BLANK;
      else sg = 7'($urandom);
      dpn = 1'($urandom_range(0, 1));
      if (nc_run >= 2) begin
        an  = ~oh;
        dur = $urandom_range(17, 40);
      end else if ($urandom_range(0, 4) == 0) begin
        dur = 16 + $urandom_range(0, 1);
      end else begin
        dur = $urandom_range(5, 40);
      end
      if ({an, dpn, sg} == prev) sg = sg ^ 7'h01;
      prev = {an, dpn, sg};
      if ($countones(~an) == 1 && dur >= STABLE + 1) begin
        k = 0;
        for (int j = 0; j < 4; j++) if (an[j] == 1'b0) k = j;
        dec = ref_decode(sg);
        m_bcd[k]  = dec[3:0];
        m_err[k]  = dec[4];
        m_dp[k]   = ~dpn;
        m_seen[k] = 1'b1;
        if (m_seen == 4'hF) begin
          exp_q.push_back(frame_t'({m_bcd, m_dp, m_err}));
          m_seen = '0;
        end
        nc_run = 0;
      end else begin
        nc_run++;
      end
      dwell(an, dpn, sg, dur);
    end
    dark(40);
    chk("random frame count", act_q.size(), exp_q.size());
    nmin = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("random frame%0d bcd", i), act_q[i].bcd, exp_q[i].bcd);
      chk($sformatf("random frame%0d points", i), act_q[i].dp, exp_q[i].dp);
      chk($sformatf("random frame%0d error", i), act_q[i].err, exp_q[i].err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
